// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request legality checks used at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic is_illegal(input logic wen, input logic [2:0] funct3);
        logic bad;
        if (wen) begin
            bad = (funct3 > 3'd2);
        end else begin
            bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Data-memory bus between the LSU (initiator) and the memory (responder).
interface lsu_mem_initiator_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication/mask generation and load
// extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store lane replication and mask, plus load lane selection
    always_comb begin
        o_wdata = i_wdata;
        o_wmask = 4'b1111;
        case (i_funct3[1:0])
            2'b00: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_wmask = 4'b0001 << i_addr_lo;
            end
            2'b01: begin
                o_wdata = {2{i_wdata[15:0]}};
                o_wmask = 4'b0011 << i_addr_lo;
            end
            default: begin
                o_wdata = i_wdata;
                o_wmask = 4'b1111;
            end
        endcase

        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        if (i_addr_lo[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end

        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_W:    o_rdata = i_rdata;
            F3_BU:   o_rdata = {24'h000000, w_byte};
            F3_HU:   o_rdata = {16'h0000, w_half};
            default: o_rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit, initiator side of the data-memory bus: accepts one
// access, runs a single bus transaction with timeout, returns the result.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_wen,
    input  logic [2:0]          i_req_funct3,
    input  logic [31:0]         i_req_addr,
    input  logic [31:0]         i_req_wdata,
    lsu_mem_initiator_if.master mem_bus,
    output logic                o_rsp_valid,
    output logic [31:0]         o_rsp_rdata,
    output logic                o_rsp_err
);

    lsu_state_e  r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic        r_wen, w_wen_nxt;
    logic [2:0]  r_funct3, w_funct3_nxt;
    logic [1:0]  r_addr_lo, w_addr_lo_nxt;

    logic        r_mem_req_valid, w_mem_req_valid_nxt;
    logic        r_mem_wen, w_mem_wen_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [3:0]  r_mem_wmask, w_mem_wmask_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic        r_rsp_err, w_rsp_err_nxt;

    logic        w_idle;
    logic [2:0]  w_fmt_funct3;
    logic [1:0]  w_fmt_addr_lo;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wmask;
    logic [31:0] w_ld_rdata;
    logic        w_bad_req;

    // One formatter serves both paths: live request when idle, latched one after
    assign w_idle        = (r_state == ST_IDLE);
    assign w_fmt_funct3  = w_idle ? i_req_funct3 : r_funct3;
    assign w_fmt_addr_lo = w_idle ? i_req_addr[1:0] : r_addr_lo;
    assign w_bad_req     = is_illegal(i_req_wen, i_req_funct3) ||
                           is_misaligned(i_req_funct3, i_req_addr[1:0]);

    lsu_align u_align (
        .i_funct3  (w_fmt_funct3),
        .i_addr_lo (w_fmt_addr_lo),
        .i_wdata   (i_req_wdata),
        .i_rdata   (mem_bus.mem_rdata),
        .o_wdata   (w_st_wdata),
        .o_wmask   (w_st_wmask),
        .o_rdata   (w_ld_rdata)
    );

    // FSM state, request latch and timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_wen     <= 1'b0;
            r_funct3  <= 3'd0;
            r_addr_lo <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wen     <= w_wen_nxt;
            r_funct3  <= w_funct3_nxt;
            r_addr_lo <= w_addr_lo_nxt;
        end
    end

    // Next-state and next-output decode; outputs are registered so they
    // change on the same edge as the state they belong to
    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_wen_nxt           = r_wen;
        w_funct3_nxt        = r_funct3;
        w_addr_lo_nxt       = r_addr_lo;
        w_mem_req_valid_nxt = r_mem_req_valid;
        w_mem_wen_nxt       = r_mem_wen;
        w_mem_addr_nxt      = r_mem_addr;
        w_mem_wdata_nxt     = r_mem_wdata;
        w_mem_wmask_nxt     = r_mem_wmask;
        w_rsp_valid_nxt     = 1'b0;
        w_rsp_rdata_nxt     = 32'h0000_0000;
        w_rsp_err_nxt       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_wen_nxt     = i_req_wen;
                    w_funct3_nxt  = i_req_funct3;
                    w_addr_lo_nxt = i_req_addr[1:0];
                    if (w_bad_req) begin
                        w_state_nxt     = ST_DONE;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt         = ST_REQ;
                        w_mem_req_valid_nxt = 1'b1;
                        w_mem_wen_nxt       = i_req_wen;
                        w_mem_addr_nxt      = {i_req_addr[31:2], 2'b00};
                        w_mem_wdata_nxt     = i_req_wen ? w_st_wdata : 32'h0000_0000;
                        w_mem_wmask_nxt     = i_req_wen ? w_st_wmask : 4'b0000;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_bus.mem_req_ready) begin
                    w_state_nxt         = ST_WAIT;
                    w_cnt_nxt           = {CNT_W{1'b0}};
                    w_mem_req_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_bus.mem_rsp_valid) begin
                    w_state_nxt     = ST_DONE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_wen ? 32'h0000_0000 : w_ld_rdata;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt     = ST_DONE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered bus and writeback outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req_valid <= 1'b0;
            r_mem_wen       <= 1'b0;
            r_mem_addr      <= 32'h0000_0000;
            r_mem_wdata     <= 32'h0000_0000;
            r_mem_wmask     <= 4'b0000;
            r_rsp_valid     <= 1'b0;
            r_rsp_rdata     <= 32'h0000_0000;
            r_rsp_err       <= 1'b0;
        end else begin
            r_mem_req_valid <= w_mem_req_valid_nxt;
            r_mem_wen       <= w_mem_wen_nxt;
            r_mem_addr      <= w_mem_addr_nxt;
            r_mem_wdata     <= w_mem_wdata_nxt;
            r_mem_wmask     <= w_mem_wmask_nxt;
            r_rsp_valid     <= w_rsp_valid_nxt;
            r_rsp_rdata     <= w_rsp_rdata_nxt;
            r_rsp_err       <= w_rsp_err_nxt;
        end
    end

    assign o_req_ready           = w_idle;
    assign mem_bus.mem_req_valid = r_mem_req_valid;
    assign mem_bus.mem_wen       = r_mem_wen;
    assign mem_bus.mem_addr      = r_mem_addr;
    assign mem_bus.mem_wdata     = r_mem_wdata;
    assign mem_bus.mem_wmask     = r_mem_wmask;
    assign o_rsp_valid           = r_rsp_valid;
    assign o_rsp_rdata           = r_rsp_rdata;
    assign o_rsp_err             = r_rsp_err;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: a scripted memory responder drives
// the bus, expected writeback results are queued at issue and popped on rsp.
module tb_lsu_mem_initiator;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_wen;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    lsu_mem_initiator_if mem_if ();

    lsu_mem_initiator #(.TIMEOUT(8), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_wen    (i_req_wen),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .mem_bus      (mem_if.master),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec;
    int   n_miss;
    exp_t sb_q[$];

    // Observations of the most recent transaction
    logic        obs_got;
    int          obs_cyc;
    logic [31:0] obs_rdata;
    logic        obs_err;
    exp_t        obs_exp;
    logic        obs_seen_req;
    int          obs_hs_cyc;
    logic        obs_wen;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_wmask;
    logic        obs_stable;

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd2:    return w;
            3'd4:    return {24'h0, sh[7:0]};
            3'd5:    return {16'h0, sh[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic err_model(input logic wen, input logic [2:0] f3, input logic [1:0] off);
        logic ill;
        ill = wen ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        return ill || (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0);
    endfunction

    // Issue one request and act as memory; rsp_dly counts cycles after the
    // handshake (0 = never respond). Pops the scoreboard entry on response.
    task automatic run_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int rdy_dly, input int rsp_dly,
                           input logic [31:0] rd);
        int req_cyc;
        req_cyc      = 0;
        obs_got      = 1'b0;
        obs_cyc      = -1;
        obs_rdata    = 32'h0;
        obs_err      = 1'b0;
        obs_seen_req = 1'b0;
        obs_hs_cyc   = -1;
        obs_stable   = 1'b1;
        obs_exp      = '0;
        i_req_valid  = 1'b1;
        i_req_wen    = wen;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        @(negedge clk);
        i_req_valid  = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            mem_if.mem_rsp_valid = 1'b0;
            mem_if.mem_req_ready = 1'b0;
            mem_if.mem_rdata     = 32'h0;
            if (o_rsp_valid) begin
                obs_got   = 1'b1;
                obs_cyc   = c;
                obs_rdata = o_rsp_rdata;
                obs_err   = o_rsp_err;
                break;
            end
            if (mem_if.mem_req_valid) begin
                if (!obs_seen_req) begin
                    obs_wen   = mem_if.mem_wen;
                    obs_addr  = mem_if.mem_addr;
                    obs_wdata = mem_if.mem_wdata;
                    obs_wmask = mem_if.mem_wmask;
                end else if (obs_wen !== mem_if.mem_wen || obs_addr !== mem_if.mem_addr ||
                             obs_wdata !== mem_if.mem_wdata || obs_wmask !== mem_if.mem_wmask) begin
                    obs_stable = 1'b0;
                end
                obs_seen_req = 1'b1;
                if (req_cyc >= rdy_dly) begin
                    mem_if.mem_req_ready = 1'b1;
                    obs_hs_cyc = c;
                end
                req_cyc++;
            end
            if (rsp_dly > 0 && obs_hs_cyc >= 0 && c == obs_hs_cyc + rsp_dly) begin
                mem_if.mem_rsp_valid = 1'b1;
                mem_if.mem_rdata     = rd;
            end
            @(negedge clk);
        end
        if (sb_q.size() > 0) obs_exp = sb_q.pop_front();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (o_req_ready !== 1'b1 || mem_if.mem_req_valid !== 1'b0 || mem_if.mem_wen !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_ctl: got ready=%b mreq=%b wen=%b expected 1 0 0",
                     o_req_ready, mem_if.mem_req_valid, mem_if.mem_wen);
        end
        n_vec++;
        if ({mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wmask} !== 68'h0) begin
            n_miss++;
            $display("FAIL reset_bus: got addr=%h wdata=%h mask=%b expected zeros",
                     mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wmask);
        end
        n_vec++;
        if ({o_rsp_valid, o_rsp_err, o_rsp_rdata} !== 34'h0) begin
            n_miss++;
            $display("FAIL reset_rsp: got v=%b e=%b d=%h expected zeros", o_rsp_valid, o_rsp_err, o_rsp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw();
        sb_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
        run_txn(1'b0, 3'd2, 32'h8000_0004, 32'h0, 0, 1, 32'hDEADBEEF);
        n_vec++;
        if (obs_addr !== 32'h8000_0004 || obs_wmask !== 4'b0000 || obs_wen !== 1'b0) begin
            n_miss++;
            $display("FAIL lw_bus: got addr=%h mask=%b wen=%b expected 80000004 0000 0", obs_addr, obs_wmask, obs_wen);
        end
        n_vec++;
        if (obs_cyc !== 3) begin
            n_miss++;
            $display("FAIL lw_latency: got %0d expected 3", obs_cyc);
        end
        n_vec++;
        if (!obs_got || obs_rdata !== obs_exp.rdata || obs_err !== obs_exp.err) begin
            n_miss++;
            $display("FAIL lw_rsp: got v=%b d=%h e=%b expected d=%h e=%b", obs_got, obs_rdata, obs_err, obs_exp.rdata, obs_exp.err);
        end
    endtask

    task automatic test_lb_lbu();
        sb_q.push_back('{rdata: 32'hFFFFFF80, err: 1'b0});
        run_txn(1'b0, 3'd0, 32'h8000_0003, 32'h0, 0, 1, 32'h80FF1234);
        n_vec++;
        if (!obs_got || obs_rdata !== obs_exp.rdata || obs_err !== obs_exp.err) begin
            n_miss++;
            $display("FAIL lb_rsp: got d=%h e=%b expected d=%h e=%b", obs_rdata, obs_err, obs_exp.rdata, obs_exp.err);
        end
        sb_q.push_back('{rdata: 32'h00000080, err: 1'b0});
        run_txn(1'b0, 3'd4, 32'h8000_0003, 32'h0, 0, 1, 32'h80FF1234);
        n_vec++;
        if (!obs_got || obs_rdata !== obs_exp.rdata || obs_err !== obs_exp.err) begin
            n_miss++;
            $display("FAIL lbu_rsp: got d=%h e=%b expected d=%h e=%b", obs_rdata, obs_err, obs_exp.rdata, obs_exp.err);
        end
    endtask

    task automatic test_sh_backpressure();
        sb_q.push_back('{rdata: 32'h0, err: 1'b0});
        run_txn(1'b1, 3'd1, 32'h8000_0002, 32'h0000ABCD, 4, 1, 32'h5555AAAA);
        n_vec++;
        if (obs_wdata !== 32'hABCDABCD || obs_wmask !== 4'b1100 || obs_wen !== 1'b1 || obs_addr !== 32'h8000_0000) begin
            n_miss++;
            $display("FAIL sh_bus: got wd=%h mask=%b wen=%b addr=%h expected abcdabcd 1100 1 80000000",
                     obs_wdata, obs_wmask, obs_wen, obs_addr);
        end
        n_vec++;
        if (obs_stable !== 1'b1 || obs_hs_cyc !== 5) begin
            n_miss++;
            $display("FAIL sh_hold: got stable=%b hs_cyc=%0d expected 1 5", obs_stable, obs_hs_cyc);
        end
        n_vec++;
        if (!obs_got || obs_cyc !== 7 || obs_rdata !== obs_exp.rdata || obs_err !== obs_exp.err) begin
            n_miss++;
            $display("FAIL sh_rsp: got v=%b cyc=%0d d=%h e=%b expected cyc=7 d=%h e=%b",
                     obs_got, obs_cyc, obs_rdata, obs_err, obs_exp.rdata, obs_exp.err);
        end
    endtask

    task automatic test_misaligned();
        sb_q.push_back('{rdata: 32'h0, err: 1'b1});
        run_txn(1'b0, 3'd2, 32'h8000_0001, 32'h0, 0, 1, 32'h12345678);
        n_vec++;
        if (obs_seen_req !== 1'b0 || obs_cyc !== 1) begin
            n_miss++;
            $display("FAIL misalign_path: got bus=%b cyc=%0d expected 0 1", obs_seen_req, obs_cyc);
        end
        n_vec++;
        if (!obs_got || obs_rdata !== obs_exp.rdata || obs_err !== obs_exp.err) begin
            n_miss++;
            $display("FAIL misalign_rsp: got d=%h e=%b expected d=%h e=%b", obs_rdata, obs_err, obs_exp.rdata, obs_exp.err);
        end
    endtask

    task automatic test_timeout();
        sb_q.push_back('{rdata: 32'h0, err: 1'b1});
        run_txn(1'b0, 3'd2, 32'h8000_0010, 32'h0, 0, 0, 32'h0);
        n_vec++;
        if (!obs_got || obs_cyc - (obs_hs_cyc + 1) !== 8 || obs_err !== obs_exp.err || obs_rdata !== obs_exp.rdata) begin
            n_miss++;
            $display("FAIL timeout: got v=%b wait_cycles=%0d e=%b d=%h expected 8 e=%b d=%h",
                     obs_got, obs_cyc - (obs_hs_cyc + 1), obs_err, obs_rdata, obs_exp.err, obs_exp.rdata);
        end
        sb_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
        run_txn(1'b0, 3'd2, 32'h8000_0010, 32'h0, 0, 8, 32'hCAFEF00D);
        n_vec++;
        if (!obs_got || obs_cyc - (obs_hs_cyc + 1) !== 8 || obs_err !== obs_exp.err || obs_rdata !== obs_exp.rdata) begin
            n_miss++;
            $display("FAIL timeout_race: got v=%b wait_cycles=%0d e=%b d=%h expected 8 e=%b d=%h",
                     obs_got, obs_cyc - (obs_hs_cyc + 1), obs_err, obs_rdata, obs_exp.err, obs_exp.rdata);
        end
    endtask

    task automatic test_load_matrix();
        logic [31:0] w;
        logic        e;
        for (int f = 0; f < 8; f++) begin
            for (int o = 0; o < 4; o++) begin
                w = $urandom() | 32'h8080_8080;
                if (o[0]) w = w & 32'h7F7F_7F7F;
                e = err_model(1'b0, f[2:0], o[1:0]);
                sb_q.push_back('{rdata: e ? 32'h0 : ld_model(f[2:0], o[1:0], w), err: e});
                run_txn(1'b0, f[2:0], 32'h8000_0100 + o, 32'h0, 0, 1, w);
                n_vec++;
                if (!obs_got || obs_rdata !== obs_exp.rdata || obs_err !== obs_exp.err ||
                    obs_seen_req !== !e || obs_cyc !== (e ? 1 : 3)) begin
                    n_miss++;
                    $display("FAIL load_f%0d_o%0d: got v=%b d=%h e=%b bus=%b cyc=%0d expected d=%h e=%b",
                             f, o, obs_got, obs_rdata, obs_err, obs_seen_req, obs_cyc, obs_exp.rdata, obs_exp.err);
                end
            end
        end
    endtask

    task automatic test_store_matrix();
        logic [31:0] xd;
        logic [3:0]  xm;
        logic        e;
        for (int f = 0; f < 4; f++) begin
            for (int o = 0; o < 4; o++) begin
                e  = err_model(1'b1, f[2:0], o[1:0]);
                xd = (f == 0) ? {4{8'hA5}} : (f == 1) ? {2{16'h56A5}} : 32'h123456A5;
                xm = (f == 0) ? (4'b0001 << o) : (f == 1) ? (4'b0011 << o) : 4'b1111;
                sb_q.push_back('{rdata: 32'h0, err: e});
                run_txn(1'b1, f[2:0], 32'h8000_0200 + o, 32'h123456A5, 1, 2, 32'hFFFF_FFFF);
                n_vec++;
                if (!obs_got || obs_err !== obs_exp.err || obs_rdata !== obs_exp.rdata || obs_seen_req !== !e ||
                    (!e && (obs_wdata !== xd || obs_wmask !== xm || obs_addr !== 32'h8000_0200))) begin
                    n_miss++;
                    $display("FAIL store_f%0d_o%0d: got e=%b d=%h wd=%h mask=%b addr=%h expected e=%b wd=%h mask=%b",
                             f, o, obs_err, obs_rdata, obs_wdata, obs_wmask, obs_addr, obs_exp.err, xd, xm);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        // Reset while the request is still presented on the bus
        i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_funct3 = 3'd2; i_req_addr = 32'h8000_0020;
        @(negedge clk);
        i_req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (mem_if.mem_req_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL rst_in_req: got mreq=%b ready=%b expected 0 1", mem_if.mem_req_valid, o_req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        // Reset during WAIT, then a stray response
        i_req_valid = 1'b1;
        @(negedge clk);
        i_req_valid = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_if.mem_req_ready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (mem_if.mem_req_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL rst_in_wait: got mreq=%b ready=%b expected 0 1", mem_if.mem_req_valid, o_req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rdata = 32'h1111_2222;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mem_if.mem_rsp_valid = 1'b0;
            if (o_rsp_valid || mem_if.mem_req_valid || !o_req_ready) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_miss++;
            $display("FAIL rst_stray_rsp: got activity=%b expected 0", seen);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_funct3 = 3'd0;
        i_req_addr = 32'h0; i_req_wdata = 32'h0;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rdata = 32'h0;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_backpressure();
        test_misaligned();
        test_timeout();
        test_load_matrix();
        test_store_matrix();
        test_reset_mid();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
